// File: rtl/pipeline_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_pkg
// Purpose  : Shared constants for the pipeline-control load/store path:
//            arbiter state codes, LDST order encodings and direction codes.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_control_pkg;

    // Arbiter state codes (kept as plain constants for legacy compatibility)
    typedef logic [1:0] pl_arb_state_t;
    localparam logic [1:0] PL_ARB_IDLE  = 2'd0;
    localparam logic [1:0] PL_ARB_OWNED = 2'd1;
    localparam logic [1:0] PL_ARB_WAIT  = 2'd2;

    // Access size encodings on the ORDER field
    localparam logic [1:0] LDST_ORDER_BYTE = 2'b00;
    localparam logic [1:0] LDST_ORDER_HALF = 2'b01;
    localparam logic [1:0] LDST_ORDER_WORD = 2'b10;
    localparam logic [1:0] LDST_ORDER_NONE = 2'b11;

    // Direction encodings on the RW field
    localparam logic LDST_RW_READ  = 1'b0;
    localparam logic LDST_RW_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pipeline_control_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request bit found searching upward from last+1 with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_control_rr_pick #(
    parameter int REQ_N = 3,
    parameter int REQ_W = 2
) (
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_W-1:0] last,
    output logic             valid,
    output logic [REQ_W-1:0] index
);

    int               cand;
    logic [REQ_W-1:0] cand_idx;

    // Walk candidates from the farthest to the nearest so the nearest set bit
    // after 'last' is the one that sticks.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = REQ_N; i >= 1; i--) begin
            cand     = (int'(last) + i) % REQ_N;
            cand_idx = cand[REQ_W-1:0];
            if (req[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_control_ldst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_ldst_arbiter
// Purpose  : Shares the pipeline-control load/store port among REQ_N
//            sub-sequencers. Round-robin grant held for the owner's whole
//            USE window, one outstanding access, response routed to owner.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_control_ldst_arbiter
    import pipeline_control_pkg::*;
#(
    parameter int REQ_N = 3,
    parameter int REQ_W = 2
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iRESET_SYNC,
    input  logic [REQ_N-1:0]    iREQ_USE,
    input  logic [REQ_N-1:0]    iREQ_REQ,
    input  logic [2*REQ_N-1:0]  iREQ_ORDER,
    input  logic [REQ_N-1:0]    iREQ_RW,
    input  logic [32*REQ_N-1:0] iREQ_ADDR,
    input  logic [32*REQ_N-1:0] iREQ_DATA,
    output logic [REQ_N-1:0]    oREQ_BUSY,
    output logic [REQ_N-1:0]    oREQ_VALID,
    output logic [31:0]         oREQ_DATA,
    output logic [REQ_N-1:0]    oREQ_GRANT,
    output logic                oLDST_USE,
    output logic                oLDST_REQ,
    input  logic                iLDST_BUSY,
    output logic [1:0]          oLDST_ORDER,
    output logic                oLDST_RW,
    output logic [31:0]         oLDST_ADDR,
    output logic [31:0]         oLDST_DATA,
    input  logic                iLDST_REQ,
    input  logic [31:0]         iLDST_DATA
);

    pl_arb_state_t    state;
    logic [REQ_W-1:0] b_owner;
    logic [REQ_W-1:0] b_last;

    logic             pick_valid;
    logic [REQ_W-1:0] pick_index;
    logic             accept;

    logic [1:0]       order_arr [REQ_N];
    logic [31:0]      addr_arr  [REQ_N];
    logic [31:0]      data_arr  [REQ_N];

    // Split the flat per-requester buses into indexable arrays
    for (genvar g = 0; g < REQ_N; g++) begin : g_unpack
        assign order_arr[g] = iREQ_ORDER[2*g +: 2];
        assign addr_arr[g]  = iREQ_ADDR[32*g +: 32];
        assign data_arr[g]  = iREQ_DATA[32*g +: 32];
    end

    pipeline_control_rr_pick #(
        .REQ_N (REQ_N),
        .REQ_W (REQ_W)
    ) u_rr_pick (
        .req   (iREQ_USE),
        .last  (b_last),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign accept = (state == PL_ARB_OWNED) && iREQ_REQ[b_owner] && !iLDST_BUSY;

    // Arbiter state, owner and round-robin pointer
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state   <= PL_ARB_IDLE;
            b_owner <= '0;
            b_last  <= REQ_W'(REQ_N - 1);
        end else if (iRESET_SYNC) begin
            state   <= PL_ARB_IDLE;
            b_owner <= '0;
            b_last  <= REQ_W'(REQ_N - 1);
        end else begin
            case (state)
                PL_ARB_IDLE: begin
                    if (pick_valid) begin
                        b_owner <= pick_index;
                        b_last  <= pick_index;
                        state   <= PL_ARB_OWNED;
                    end
                end
                PL_ARB_OWNED: begin
                    // An accepted access wins over a simultaneous USE drop;
                    // the window closes once its response returns.
                    if (accept)
                        state <= PL_ARB_WAIT;
                    else if (!iREQ_USE[b_owner])
                        state <= PL_ARB_IDLE;
                end
                PL_ARB_WAIT: begin
                    if (iLDST_REQ)
                        state <= iREQ_USE[b_owner] ? PL_ARB_OWNED : PL_ARB_IDLE;
                end
                default: state <= PL_ARB_IDLE;
            endcase
        end
    end

    // Owner muxing onto the downstream port and response routing
    always_comb begin
        oREQ_BUSY   = '1;
        oREQ_VALID  = '0;
        oREQ_DATA   = iLDST_DATA;
        oREQ_GRANT  = '0;
        oLDST_USE   = 1'b0;
        oLDST_REQ   = 1'b0;
        oLDST_ORDER = LDST_ORDER_BYTE;
        oLDST_RW    = LDST_RW_READ;
        oLDST_ADDR  = '0;
        oLDST_DATA  = '0;
        if (state == PL_ARB_OWNED || state == PL_ARB_WAIT) begin
            oREQ_GRANT  = REQ_N'(1) << b_owner;
            oLDST_USE   = 1'b1;
            oLDST_ORDER = order_arr[b_owner];
            oLDST_RW    = iREQ_RW[b_owner];
            oLDST_ADDR  = addr_arr[b_owner];
            oLDST_DATA  = data_arr[b_owner];
        end
        if (state == PL_ARB_OWNED) begin
            oLDST_REQ          = iREQ_REQ[b_owner];
            oREQ_BUSY[b_owner] = iLDST_BUSY;
        end
        if (state == PL_ARB_WAIT) begin
            oREQ_VALID[b_owner] = iLDST_REQ;
        end
    end

endmodule
`default_nettype wire
